// File: rtl/seq_multiplier_param.sv
// Parametrised shift-add sequential multiplier with signed/unsigned mode.
// Operands are captured on start and turned into magnitudes. WIDTH add/shift
// iterations build the unsigned product. The sign is applied once in FIX, so
// the product port only changes on the done cycle.
//
// Handshake: start is accepted on any rising edge where busy=0. The done cycle
// counts as idle, so a new start can be taken there. busy stays high from the
// cycle after acceptance until the result is written. done is a single-cycle
// pulse, high in the cycle after the result is written. product holds its value
// until the next done.
module seq_multiplier_param #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     a_in,
    input  logic [WIDTH-1:0]     b_in,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic                 neg_q, neg_d;
    logic [WIDTH-1:0]     mag_a_q, mag_a_d;
    logic [WIDTH-1:0]     p_hi_q, p_hi_d;
    // Low half of P. It starts as |b| and the partial product shifts into it.
    logic [WIDTH-1:0]     p_lo_q, p_lo_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
    logic                 done_q, done_d;

    // Datapath helpers: one extra adder bit keeps the carry for the shift.
    logic [WIDTH-1:0]     addend;
    logic [WIDTH:0]       sum;
    logic [2*WIDTH-1:0]   full;
    logic [2*WIDTH-1:0]   full_neg;

    assign addend   = p_lo_q[0] ? mag_a_q : '0;
    assign sum      = {1'b0, p_hi_q} + {1'b0, addend};
    assign full     = {p_hi_q, p_lo_q};
    assign full_neg = -full;

    // State and datapath registers; reset clears everything and aborts any run.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            neg_q     <= 1'b0;
            mag_a_q   <= '0;
            p_hi_q    <= '0;
            p_lo_q    <= '0;
            cnt_q     <= '0;
            product_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            neg_q     <= neg_d;
            mag_a_q   <= mag_a_d;
            p_hi_q    <= p_hi_d;
            p_lo_q    <= p_lo_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            done_q    <= done_d;
        end
    end

    // Next-state and datapath update for IDLE capture, RUN iteration and FIX sign.
    always_comb begin
        state_d   = state_q;
        neg_d     = neg_q;
        mag_a_d   = mag_a_q;
        p_hi_d    = p_hi_q;
        p_lo_d    = p_lo_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    neg_d   = signed_mode & (a_in[WIDTH-1] ^ b_in[WIDTH-1]);
                    // The most-negative value negates to 2^(WIDTH-1), which still fits unsigned.
                    mag_a_d = (signed_mode && a_in[WIDTH-1]) ? -a_in : a_in;
                    p_lo_d  = (signed_mode && b_in[WIDTH-1]) ? -b_in : b_in;
                    p_hi_d  = '0;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                p_hi_d = sum[WIDTH:1];
                p_lo_d = {sum[0], p_lo_q[WIDTH-1:1]};
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                // A zero product negates to zero, so no special case is needed for it.
                product_d = neg_q ? full_neg : full;
                done_d    = 1'b1;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy    = (state_q != ST_IDLE);
    assign done    = done_q;
    assign product = product_q;

endmodule

// File: tb/tb_seq_multiplier_param.sv
// Bench for seq_multiplier_param at WIDTH=8 and WIDTH=16: directed vector table,
// hand-written multi-cycle sequences, and a randomised run against a cycle model.
module tb_seq_multiplier_param;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start8 = 1'b0, sm8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy8, done8;
    logic [15:0] prod8;
    logic        start16 = 1'b0, sm16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        busy16, done16;
    logic [31:0] prod16;

    int n_cmp = 0;
    int n_bad = 0;

    seq_multiplier_param #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .signed_mode(sm8),
        .a_in(a8), .b_in(b8), .busy(busy8), .done(done8), .product(prod8)
    );

    seq_multiplier_param #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .signed_mode(sm16),
        .a_in(a16), .b_in(b16), .busy(busy16), .done(done16), .product(prod16)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 30) $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // reference: plain integer product of the operands' values, mod 2^(2w)
    function automatic logic [63:0] ref_mul(input int w, input bit sm,
                                            input logic [31:0] a, input logic [31:0] b);
        longint av, bv;
        logic [63:0] m;
        av = longint'(a);
        bv = longint'(b);
        if (sm && a[w-1]) av = av - (longint'(1) << w);
        if (sm && b[w-1]) bv = bv - (longint'(1) << w);
        m = (64'd1 << (2 * w)) - 64'd1;
        return 64'(av * bv) & m;
    endfunction

    // scoreboard: at most one result in flight per instance, due at a known edge
    typedef struct {
        int          k;
        longint      due;
        logic [63:0] val;
    } exp_t;
    exp_t        exp_q[$];
    logic [63:0] last_prod [2];
    int          ops [2];
    longint      cyc = 0;

    logic        s_rst, s_st8, s_sm8, s_st16, s_sm16;
    logic [7:0]  s_a8, s_b8;
    logic [15:0] s_a16, s_b16;

    initial begin
        last_prod[0] = '0; last_prod[1] = '0;
        ops[0] = 0; ops[1] = 0;
    end

    task automatic sb_step(input int k, input int w, input logic rst, input logic st, input logic sm,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic dn, input logic bz, input logic [63:0] pr);
        int   idx;
        logic edone, ebusy;
        idx = -1;
        edone = 1'b0;
        ebusy = 1'b0;
        foreach (exp_q[i]) if (exp_q[i].k == k) idx = i;
        if (!rst) begin
            if (idx >= 0) exp_q.delete(idx);
            last_prod[k] = '0;
        end else begin
            if (idx >= 0 && exp_q[idx].due == cyc) begin
                edone = 1'b1;
                last_prod[k] = exp_q[idx].val;
                exp_q.delete(idx);
            end else if (idx < 0 && st) begin
                exp_q.push_back('{k: k, due: cyc + w + 1, val: ref_mul(w, sm, a, b)});
                ops[k]++;
            end
            foreach (exp_q[i]) if (exp_q[i].k == k) ebusy = 1'b1;
        end
        chk(k ? "done16" : "done8", {63'd0, dn}, {63'd0, edone});
        chk(k ? "busy16" : "busy8", {63'd0, bz}, {63'd0, ebusy});
        chk(k ? "prod16" : "prod8", pr, last_prod[k]);
    endtask

    // inputs are sampled at the active edge, outputs compared half a cycle later
    always @(posedge clk) begin
        cyc++;
        s_rst = rst_n;
        s_st8 = start8;   s_sm8 = sm8;   s_a8 = a8;   s_b8 = b8;
        s_st16 = start16; s_sm16 = sm16; s_a16 = a16; s_b16 = b16;
    end

    always @(negedge clk) begin
        sb_step(0, 8, s_rst, s_st8, s_sm8, {24'd0, s_a8}, {24'd0, s_b8},
                done8, busy8, {48'd0, prod8});
        sb_step(1, 16, s_rst, s_st16, s_sm16, {16'd0, s_a16}, {16'd0, s_b16},
                done16, busy16, {32'd0, prod16});
    end

    // driver: one start pulse, then wait (bounded) for done
    task automatic op(input int w, input bit sm, input logic [15:0] a, input logic [15:0] b,
                      output logic [31:0] p, output int lat);
        @(posedge clk); #1;
        if (w == 8) begin start8 = 1'b1; sm8 = sm; a8 = a[7:0]; b8 = b[7:0]; end
        else begin start16 = 1'b1; sm16 = sm; a16 = a; b16 = b; end
        @(posedge clk); #1;
        start8 = 1'b0; start16 = 1'b0;
        lat = -1;
        p = '0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if ((w == 8) ? done8 : done16) begin
                lat = i;
                p = (w == 8) ? {16'd0, prod8} : prod16;
                break;
            end
        end
    endtask

    task automatic wait_done8(output int lat);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (done8) begin lat = i; break; end
        end
    endtask

    function automatic logic [15:0] pick(input int w);
        logic [15:0] m;
        m = 16'((32'd1 << w) - 32'd1);
        case ($urandom_range(0, 5))
            0: return 16'd0;
            1: return m;
            2: return 16'(32'd1 << (w - 1));
            3: return 16'((32'd1 << (w - 1)) - 32'd1);
            default: return 16'($urandom) & m;
        endcase
    endfunction

    typedef struct {
        int          w;
        bit          sm;
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs[13];
    logic [31:0] p;
    int          lat;
    int          cnt;
    bit          seen;

    initial begin
        vecs[0]  = '{8,  1'b0, 16'h00FF, 16'h00FF, 32'h0000FE01};
        vecs[1]  = '{8,  1'b1, 16'h0080, 16'h0080, 32'h00004000};
        vecs[2]  = '{8,  1'b1, 16'h00FD, 16'h0005, 32'h0000FFF1};
        vecs[3]  = '{8,  1'b1, 16'h0000, 16'h00FF, 32'h00000000};
        vecs[4]  = '{8,  1'b0, 16'h0007, 16'h0006, 32'h0000002A};
        vecs[5]  = '{8,  1'b0, 16'h000C, 16'h000C, 32'h00000090};
        vecs[6]  = '{8,  1'b1, 16'h007F, 16'h0080, 32'h0000C080};
        vecs[7]  = '{8,  1'b0, 16'h0080, 16'h0002, 32'h00000100};
        vecs[8]  = '{8,  1'b1, 16'h00FF, 16'h00FF, 32'h00000001};
        vecs[9]  = '{8,  1'b0, 16'h00FF, 16'h0000, 32'h00000000};
        vecs[10] = '{16, 1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001};
        vecs[11] = '{16, 1'b1, 16'h8000, 16'h7FFF, 32'hC0008000};
        vecs[12] = '{16, 1'b1, 16'h8000, 16'h8000, 32'h40000000};

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // directed vector table
        foreach (vecs[i]) begin
            op(vecs[i].w, vecs[i].sm, vecs[i].a, vecs[i].b, p, lat);
            chk("vec_prod", {32'd0, p}, {32'd0, vecs[i].exp});
            chk("vec_latency", 64'(lat), 64'(vecs[i].w + 1));
        end

        // start while busy is ignored; start in the done cycle is accepted
        @(posedge clk); #1; start8 = 1'b1; sm8 = 1'b0; a8 = 8'd7; b8 = 8'd6;
        @(posedge clk); #1; start8 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1; start8 = 1'b1; a8 = 8'd9; b8 = 8'd9;
        @(posedge clk); #1; start8 = 1'b0; a8 = 8'd0; b8 = 8'd0;
        repeat (5) @(posedge clk);
        #1 chk("ign_early_done", {63'd0, done8}, 64'd0);
        @(posedge clk); #1;
        chk("ign_done", {63'd0, done8}, 64'd1);
        chk("ign_prod", {48'd0, prod8}, 64'd42);
        start8 = 1'b1; a8 = 8'd3; b8 = 8'd5;
        @(posedge clk); #1; start8 = 1'b0;
        wait_done8(lat);
        chk("b2b_latency", 64'(lat), 64'd9);
        chk("b2b_prod", {48'd0, prod8}, 64'd15);

        // reset in the middle of an operation
        @(posedge clk); #1; start8 = 1'b1; a8 = 8'd200; b8 = 8'd100;
        @(posedge clk); #1; start8 = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        chk("rst_busy", {63'd0, busy8}, 64'd0);
        chk("rst_done", {63'd0, done8}, 64'd0);
        chk("rst_prod", {48'd0, prod8}, 64'd0);
        @(posedge clk); #1; rst_n = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done8) seen = 1'b1;
        end
        chk("rst_no_done", {63'd0, seen}, 64'd0);
        op(8, 1'b0, 16'd12, 16'd12, p, lat);
        chk("post_rst_prod", {32'd0, p}, 64'd144);
        chk("post_rst_latency", 64'(lat), 64'd9);

        // start held high relaunches from every idle edge
        @(posedge clk); #1; start8 = 1'b1; sm8 = 1'b1; a8 = 8'hFD; b8 = 8'h05;
        cnt = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (done8) cnt++;
        end
        start8 = 1'b0;
        chk("held_dones", 64'(cnt), 64'd3);
        repeat (12) @(posedge clk);

        // randomised traffic on both instances, checked by the cycle model
        ops[0] = 0; ops[1] = 0;
        fork
            begin
                for (int g = 0; g < 30000 && ops[0] < 500; g++) begin
                    @(posedge clk); #1;
                    start8 = 1'($urandom_range(0, 1));
                    sm8 = 1'($urandom_range(0, 1));
                    a8 = pick(8)[7:0];
                    b8 = pick(8)[7:0];
                end
                start8 = 1'b0;
            end
            begin
                for (int g = 0; g < 30000 && ops[1] < 500; g++) begin
                    @(posedge clk); #1;
                    start16 = 1'($urandom_range(0, 1));
                    sm16 = 1'($urandom_range(0, 1));
                    a16 = pick(16);
                    b16 = pick(16);
                end
                start16 = 1'b0;
            end
        join
        repeat (40) @(posedge clk);
        #1;
        chk("rand_ops8", 64'(ops[0] >= 500), 64'd1);
        chk("rand_ops16", 64'(ops[1] >= 500), 64'd1);
        chk("drain_empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
